// File: rtl/fu_writeback_arb_if.sv
// Writeback arbiter bus: FU result bundles in, one registered writeback
// bundle out, plus per-FU stall and the sticky overflow flag.
interface fu_writeback_arb_if #(
    parameter int FU_COUNT     = 4,
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3
);
    localparam int FU_IDX_BITS = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;

    logic [FU_COUNT-1:0]     fu_out_valid;
    logic [INST_ID_BITS-1:0] fu_out_inst_id    [FU_COUNT];
    logic [PRN_BITS-1:0]     fu_out_prn        [FU_COUNT][MAX_OPERANDS];
    logic [63:0]             fu_out_data       [FU_COUNT][MAX_OPERANDS];
    logic [MAX_OPERANDS-1:0] fu_out_data_valid [FU_COUNT];
    logic [FU_COUNT-1:0]     fu_stall;

    logic                    wb_ready;
    logic                    wb_valid;
    logic [FU_IDX_BITS-1:0]  wb_fu_idx;
    logic [INST_ID_BITS-1:0] wb_inst_id;
    logic [PRN_BITS-1:0]     wb_prn  [MAX_OPERANDS];
    logic [63:0]             wb_data [MAX_OPERANDS];
    logic [MAX_OPERANDS-1:0] wb_data_valid;
    logic                    overflow_err;

    // Driver side: FU wrappers and the writeback consumer.
    modport master (
        output fu_out_valid, fu_out_inst_id, fu_out_prn, fu_out_data, fu_out_data_valid,
        output wb_ready,
        input  fu_stall, wb_valid, wb_fu_idx, wb_inst_id, wb_prn, wb_data, wb_data_valid,
        input  overflow_err
    );

    // Arbiter side.
    modport slave (
        input  fu_out_valid, fu_out_inst_id, fu_out_prn, fu_out_data, fu_out_data_valid,
        input  wb_ready,
        output fu_stall, wb_valid, wb_fu_idx, wb_inst_id, wb_prn, wb_data, wb_data_valid,
        output overflow_err
    );
endinterface

// File: rtl/fu_writeback_arb.sv
// Writeback arbiter: per-FU result FIFOs feeding a single registered
// writeback port, granted round-robin, with valid/ready backpressure.
// A pushed bundle becomes visible to the arbiter only once it sits in the
// FIFO (no bypass), so the minimum path is FIFO register then wb register.
module fu_writeback_arb #(
    parameter int FU_COUNT     = 4,
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int BUF_DEPTH    = 4,
    parameter int STALL_MARGIN = 2
) (
    input  logic                clk,
    input  logic                rst,
    fu_writeback_arb_if.slave   bus
);
    localparam int FU_IDX_BITS = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;
    localparam int PTR_BITS    = $clog2(BUF_DEPTH);
    localparam int CNT_BITS    = PTR_BITS + 1;

    localparam logic [CNT_BITS-1:0]    DEPTH_C  = CNT_BITS'(BUF_DEPTH);
    localparam logic [CNT_BITS-1:0]    MARGIN_C = CNT_BITS'(STALL_MARGIN);
    localparam logic [FU_IDX_BITS-1:0] LAST_FU  = FU_IDX_BITS'(FU_COUNT - 1);

    // FIFO payload storage; contents are don't-care while a slot is empty.
    logic [INST_ID_BITS-1:0] mem_inst_id [FU_COUNT][BUF_DEPTH];
    logic [PRN_BITS-1:0]     mem_prn     [FU_COUNT][BUF_DEPTH][MAX_OPERANDS];
    logic [63:0]             mem_data    [FU_COUNT][BUF_DEPTH][MAX_OPERANDS];
    logic [MAX_OPERANDS-1:0] mem_dv      [FU_COUNT][BUF_DEPTH];

    logic [PTR_BITS-1:0] rd_ptr_q [FU_COUNT];
    logic [PTR_BITS-1:0] wr_ptr_q [FU_COUNT];
    logic [CNT_BITS-1:0] count_q  [FU_COUNT];

    logic [FU_COUNT-1:0]    empty;
    logic [FU_COUNT-1:0]    full;
    logic [FU_COUNT-1:0]    pop;
    logic [FU_COUNT-1:0]    push_acc;
    logic [FU_COUNT-1:0]    push_drop;
    logic [FU_IDX_BITS-1:0] rr_ptr_q;
    logic [FU_IDX_BITS-1:0] grant_idx;
    logic [FU_IDX_BITS-1:0] cand_idx;
    logic                   grant_found;
    logic                   adv;
    int                     cand;

    assign adv = !bus.wb_valid || bus.wb_ready;

    // FIFO occupancy flags and stall, all from the registered count.
    always_comb begin
        empty        = '0;
        full         = '0;
        bus.fu_stall = '0;
        for (int i = 0; i < FU_COUNT; i++) begin
            empty[i]        = (count_q[i] == '0);
            full[i]         = (count_q[i] == DEPTH_C);
            bus.fu_stall[i] = ((DEPTH_C - count_q[i]) <= MARGIN_C);
        end
    end

    // Round-robin pick: first non-empty FIFO at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 0; k < FU_COUNT; k++) begin
            cand     = (int'(rr_ptr_q) + k) % FU_COUNT;
            cand_idx = FU_IDX_BITS'(cand);
            if (!grant_found && !empty[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Pop only the granted FIFO; a full FIFO still accepts if it pops this cycle.
    always_comb begin
        pop       = '0;
        push_acc  = '0;
        push_drop = '0;
        for (int i = 0; i < FU_COUNT; i++) begin
            pop[i]       = adv && grant_found && (grant_idx == FU_IDX_BITS'(i));
            push_acc[i]  = bus.fu_out_valid[i] && (!full[i] || pop[i]);
            push_drop[i] = bus.fu_out_valid[i] && full[i] && !pop[i];
        end
    end

    // Per-FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FU_COUNT; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < FU_COUNT; i++) begin
                if (push_acc[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_BITS'(1);
                if (pop[i])      rd_ptr_q[i] <= rd_ptr_q[i] + PTR_BITS'(1);
                count_q[i] <= count_q[i] + CNT_BITS'(push_acc[i]) - CNT_BITS'(pop[i]);
            end
        end
    end

    // Payload write at the tail; needs no reset since count gates every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FU_COUNT; i++) begin
            if (push_acc[i]) begin
                mem_inst_id[i][wr_ptr_q[i]] <= bus.fu_out_inst_id[i];
                mem_dv[i][wr_ptr_q[i]]      <= bus.fu_out_data_valid[i];
                for (int j = 0; j < MAX_OPERANDS; j++) begin
                    mem_prn[i][wr_ptr_q[i]][j]  <= bus.fu_out_prn[i][j];
                    mem_data[i][wr_ptr_q[i]][j] <= bus.fu_out_data[i][j];
                end
            end
        end
    end

    // Writeback register, round-robin pointer and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.wb_valid      <= 1'b0;
            bus.wb_fu_idx     <= '0;
            bus.wb_inst_id    <= '0;
            bus.wb_data_valid <= '0;
            for (int j = 0; j < MAX_OPERANDS; j++) begin
                bus.wb_prn[j]  <= '0;
                bus.wb_data[j] <= '0;
            end
            rr_ptr_q         <= '0;
            bus.overflow_err <= 1'b0;
        end else begin
            if (|push_drop) bus.overflow_err <= 1'b1;
            if (adv) begin
                if (grant_found) begin
                    bus.wb_valid      <= 1'b1;
                    bus.wb_fu_idx     <= grant_idx;
                    bus.wb_inst_id    <= mem_inst_id[grant_idx][rd_ptr_q[grant_idx]];
                    bus.wb_data_valid <= mem_dv[grant_idx][rd_ptr_q[grant_idx]];
                    for (int j = 0; j < MAX_OPERANDS; j++) begin
                        bus.wb_prn[j]  <= mem_prn[grant_idx][rd_ptr_q[grant_idx]][j];
                        bus.wb_data[j] <= mem_data[grant_idx][rd_ptr_q[grant_idx]][j];
                    end
                    rr_ptr_q <= (grant_idx == LAST_FU) ? '0 : grant_idx + FU_IDX_BITS'(1);
                end else begin
                    bus.wb_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fu_writeback_arb.sv
// Directed bench for fu_writeback_arb: expected bundles are queued as they
// are driven and checked in order as the writeback port presents them.
module tb_fu_writeback_arb;
    localparam int FU_COUNT     = 4;
    localparam int INST_ID_BITS = 6;
    localparam int PRN_BITS     = 6;
    localparam int MAX_OPS      = 3;
    localparam int BUF_DEPTH    = 4;
    localparam int STALL_MARGIN = 2;

    typedef struct packed {
        logic [1:0]        fu;
        logic [5:0]        id;
        logic [2:0][5:0]   prn;
        logic [2:0][63:0]  data;
        logic [2:0]        dv;
    } bundle_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    bundle_t sb[$];
    int vectors     = 0;
    int miscompares = 0;

    fu_writeback_arb_if #(
        .FU_COUNT(FU_COUNT), .INST_ID_BITS(INST_ID_BITS),
        .PRN_BITS(PRN_BITS), .MAX_OPERANDS(MAX_OPS)
    ) bus ();

    fu_writeback_arb #(
        .FU_COUNT(FU_COUNT), .INST_ID_BITS(INST_ID_BITS), .PRN_BITS(PRN_BITS),
        .MAX_OPERANDS(MAX_OPS), .BUF_DEPTH(BUF_DEPTH), .STALL_MARGIN(STALL_MARGIN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bundle_t mk(input int fu, input int id, input logic [2:0] dv);
        bundle_t b;
        b.fu = 2'(fu);
        b.id = 6'(id);
        for (int j = 0; j < MAX_OPS; j++) begin
            b.prn[j]  = 6'(id + 7 * j + 1);
            b.data[j] = 64'h5A00_0000_0000_0000 | (64'(id) << 16) | 64'(j);
        end
        b.dv = dv;
        return b;
    endfunction

    function automatic bundle_t get_wb();
        bundle_t b;
        b.fu = bus.wb_fu_idx;
        b.id = bus.wb_inst_id;
        for (int j = 0; j < MAX_OPS; j++) begin
            b.prn[j]  = bus.wb_prn[j];
            b.data[j] = bus.wb_data[j];
        end
        b.dv = bus.wb_data_valid;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.fu_out_valid = '0;
        for (int i = 0; i < FU_COUNT; i++) begin
            bus.fu_out_inst_id[i]    = '0;
            bus.fu_out_data_valid[i] = '0;
            for (int j = 0; j < MAX_OPS; j++) begin
                bus.fu_out_prn[i][j]  = '0;
                bus.fu_out_data[i][j] = '0;
            end
        end
    endtask

    task automatic drive_raw(input bundle_t b);
        int f;
        f = int'(b.fu);
        bus.fu_out_valid[f]      = 1'b1;
        bus.fu_out_inst_id[f]    = b.id;
        bus.fu_out_data_valid[f] = b.dv;
        for (int j = 0; j < MAX_OPS; j++) begin
            bus.fu_out_prn[f][j]  = b.prn[j];
            bus.fu_out_data[f][j] = b.data[j];
        end
    endtask

    task automatic drive(input bundle_t b);
        drive_raw(b);
        sb.push_back(b);
    endtask

    // Compare the presented bundle with the oldest expectation, no clock advance.
    task automatic check_head(input string tag);
        bundle_t exp;
        if (sb.size() == 0) begin
            check({tag, "_unexpected_valid"}, bus.wb_valid, 1'b0);
        end else begin
            exp = sb.pop_front();
            check({tag, "_valid"}, bus.wb_valid, 1'b1);
            check(tag, get_wb(), exp);
        end
    endtask

    // Wait (bounded) for wb_valid, check the bundle, then let it transfer.
    task automatic expect_next(input string tag);
        int n;
        n = 0;
        while (!bus.wb_valid && n < 10) begin
            tick();
            n++;
        end
        check_head(tag);
        tick();
    endtask

    task automatic check_idle(input string tag);
        bundle_t zero;
        zero = '0;
        check({tag, "_wb_valid"}, bus.wb_valid, 1'b0);
        check({tag, "_wb_bundle"}, get_wb(), zero);
        check({tag, "_stall"}, bus.fu_stall, 4'b0000);
        check({tag, "_ovf"}, bus.overflow_err, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        clear_inputs();
        sb.delete();
        tick();
        check_idle(tag);
        rst = 1'b1;
    endtask

    initial begin
        bundle_t b;
        clear_inputs();
        bus.wb_ready = 1'b1;
        rst = 1'b0;
        tick();
        do_reset("reset0");

        // Single result from FU2: two register stages to the wb port.
        b = '0;
        b.fu = 2'd2; b.id = 6'd5; b.prn[0] = 6'd7; b.data[0] = 64'hDEAD; b.dv = 3'b001;
        drive(b);
        tick();
        clear_inputs();
        check("t1_lat_first_edge", bus.wb_valid, 1'b0);
        tick();
        check_head("t1_single");
        tick();
        check("t1_idle_after", bus.wb_valid, 1'b0);

        // Round-robin fairness from rr_ptr=0.
        do_reset("reset_t2");
        drive(mk(0, 10, 3'b111));
        drive(mk(1, 11, 3'b011));
        drive(mk(2, 12, 3'b101));
        drive(mk(3, 13, 3'b110));
        tick();
        clear_inputs();
        expect_next("t2_rr_fu0");
        expect_next("t2_rr_fu1");
        expect_next("t2_rr_fu2");
        expect_next("t2_rr_fu3");
        drive(mk(1, 20, 3'b001));
        drive(mk(3, 21, 3'b100));
        tick();
        clear_inputs();
        expect_next("t2_rr2_fu1");
        expect_next("t2_rr2_fu3");
        check("t2_idle", bus.wb_valid, 1'b0);

        // Backpressure: bundle held, FU0 keeps filling, stall crosses threshold.
        do_reset("reset_t3");
        drive(mk(0, 1, 3'b111));
        tick();
        clear_inputs();
        tick();
        check("t3_first_valid", bus.wb_valid, 1'b1);
        bus.wb_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 0)      drive(mk(0, 2, 3'b010));
            else if (c == 1) drive(mk(0, 3, 3'b100));
            else             clear_inputs();
            tick();
            check("t3_hold_bundle", get_wb(), sb[0]);
            check("t3_hold_valid", bus.wb_valid, 1'b1);
            if (c == 0) check("t3_stall_cnt1", bus.fu_stall, 4'b0000);
            else        check("t3_stall_cnt2", bus.fu_stall, 4'b0001);
        end
        bus.wb_ready = 1'b1;
        expect_next("t3_drain_a");
        expect_next("t3_drain_b");
        expect_next("t3_drain_c");
        check("t3_idle", bus.wb_valid, 1'b0);

        // Full FIFO, push without pop is dropped and flagged.
        do_reset("reset_t4");
        bus.wb_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(mk(1, 50 + k, 3'b011));
            tick();
        end
        clear_inputs();
        check("t4_full_stall", bus.fu_stall, 4'b0010);
        check("t4_no_ovf_yet", bus.overflow_err, 1'b0);
        drive_raw(mk(1, 63, 3'b111));
        tick();
        clear_inputs();
        check("t4_ovf_set", bus.overflow_err, 1'b1);
        bus.wb_ready = 1'b1;
        for (int k = 0; k < 5; k++) expect_next("t4_drain");
        tick();
        check("t4_dropped_never_seen", bus.wb_valid, 1'b0);
        check("t4_ovf_sticky", bus.overflow_err, 1'b1);

        // Full FIFO, push coincident with a pop is accepted.
        do_reset("reset_t4b");
        bus.wb_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(mk(1, 20 + k, 3'b110));
            tick();
        end
        clear_inputs();
        check_head("t4b_head");
        bus.wb_ready = 1'b1;
        drive(mk(1, 29, 3'b111));
        tick();
        clear_inputs();
        check("t4b_no_ovf", bus.overflow_err, 1'b0);
        check("t4b_still_full", bus.fu_stall, 4'b0010);
        for (int k = 0; k < 5; k++) expect_next("t4b_drain");
        check("t4b_idle", bus.wb_valid, 1'b0);
        check("t4b_no_ovf_end", bus.overflow_err, 1'b0);

        // Completion-only bundle from FU3.
        drive(mk(3, 42, 3'b000));
        tick();
        clear_inputs();
        tick();
        check_head("t5_store");
        check("t5_dv_zero", bus.wb_data_valid, 3'b000);
        tick();

        // Async reset mid-operation with three FIFOs occupied and rr_ptr=2.
        do_reset("reset_t6");
        bus.wb_ready = 1'b0;
        drive(mk(1, 30, 3'b001));
        drive(mk(2, 31, 3'b001));
        drive(mk(3, 32, 3'b001));
        tick();
        clear_inputs();
        drive(mk(1, 33, 3'b010));
        drive(mk(2, 34, 3'b010));
        drive(mk(3, 35, 3'b010));
        tick();
        clear_inputs();
        check("t6_pre_valid", bus.wb_valid, 1'b1);
        check("t6_pre_idx", bus.wb_fu_idx, 2'd1);
        check("t6_pre_stall", bus.fu_stall, 4'b1100);
        #3;
        rst = 1'b0;
        #1;
        check_idle("t6_async");
        sb.delete();
        tick();
        rst = 1'b1;
        bus.wb_ready = 1'b1;
        drive(mk(1, 40, 3'b111));
        drive(mk(3, 41, 3'b111));
        tick();
        clear_inputs();
        expect_next("t6_post_fu1");
        expect_next("t6_post_fu3");
        tick();
        check("t6_no_stale", bus.wb_valid, 1'b0);
        check("t6_stall_clear", bus.fu_stall, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
